// File: rtl/mips_core_pkg.sv
// mips_core: definitions shared across the MIPS core slice.
//   ADDR_WIDTH  - byte address width used by fetch/branch logic.
//   BTB_TAG_W   - storage width of a BTB tag. Sized for the smallest legal
//                 table (2 sets); larger tables zero-extend their tag into it.
//   btb_state_e - BTB flush walker states.
//   btb_entry   - one BTB way: valid bit, tag and branch target.
package mips_core;

    localparam int ADDR_WIDTH = 26;
    localparam int BTB_TAG_W  = ADDR_WIDTH - 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [ADDR_WIDTH-1:0] target;
    } btb_entry;

endpackage

// File: rtl/btb_lru_set.sv
// btb_lru_set: age-based LRU bookkeeping and victim choice for one BTB set.
// Ages form a permutation of 0..NUM_WAYS-1; age 0 is MRU.
// Ports:
//   clk, rst     - clock; synchronous active-high reset (ages -> age[w] = w)
//   clear        - flush of this set; restores the same age ordering as reset
//   touch_en     - mark touch_way most recently used this cycle
//   touch_way    - way being touched
//   valid        - valid bits of the set's ways (owned by the table)
//   victim_way   - lowest invalid way, else the oldest way
module btb_lru_set #(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                touch_en,
    input  logic [WAY_W-1:0]    touch_way,
    input  logic [NUM_WAYS-1:0] valid,
    output logic [WAY_W-1:0]    victim_way
);

    logic [WAY_W-1:0] age [NUM_WAYS];
    logic [WAY_W-1:0] touch_age;

    assign touch_age = age[touch_way];

    // Touch: the touched way becomes 0 and every way that was younger than
    // it shifts one step older, which keeps the ages a permutation.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                age[w] <= WAY_W'(w);
            end
        end else if (touch_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age[w] <= '0;
                end else if (age[w] < touch_age) begin
                    age[w] <= age[w] + 1'b1;
                end
            end
        end
    end

    // With NUM_WAYS a power of two the oldest way always has age all-ones.
    always_comb begin
        victim_way = '0;
        if (&valid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age[w] == '1) begin
                    victim_way = WAY_W'(w);
                end
            end
        end else begin
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (!valid[w]) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with age-based LRU
// replacement and a multi-cycle flush walker.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   lookup_pc      - fetch PC to look up (pc[1:0] ignored)
//   lookup_valid   - lookup_pc is a real request
//   lookup_hit     - combinational hit indication
//   lookup_target  - hit target, or lookup_pc + 4 on a miss
//   upd_valid      - branch/jump resolved this cycle
//   upd_pc         - PC of the resolved instruction
//   upd_taken      - resolved direction
//   upd_target     - resolved target
//   flush_req      - one-cycle request to invalidate the whole table
//   flush_busy     - flush walk in progress (one set cleared per cycle)
module btb_assoc
    import mips_core::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    input  logic                  lookup_valid,
    output logic                  lookup_hit,
    output logic [ADDR_WIDTH-1:0] lookup_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  flush_req,
    output logic                  flush_busy
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    function automatic logic [IDX_W-1:0] pc_index(input logic [ADDR_WIDTH-1:0] pc);
        return IDX_W'(pc >> 2);
    endfunction

    // Tag bits above the index, zero-extended into the shared tag field.
    function automatic logic [BTB_TAG_W-1:0] pc_tag(input logic [ADDR_WIDTH-1:0] pc);
        return BTB_TAG_W'(pc >> (2 + IDX_W));
    endfunction

    btb_entry          tbl [NUM_SETS][NUM_WAYS];
    btb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  flush_cnt, flush_cnt_nxt;

    logic [IDX_W-1:0]     lk_idx, upd_idx;
    logic [BTB_TAG_W-1:0] lk_tag, upd_tag;
    logic [NUM_WAYS-1:0]  lk_match, upd_match;
    logic [WAY_W-1:0]     lk_way, upd_hit_way, upd_way;
    logic                 upd_hit, upd_en, wr_en, inv_en, lk_touch;
    logic [WAY_W-1:0]     set_victim [NUM_SETS];

    assign lk_idx  = pc_index(lookup_pc);
    assign lk_tag  = pc_tag(lookup_pc);
    assign upd_idx = pc_index(upd_pc);
    assign upd_tag = pc_tag(upd_pc);

    always_comb begin
        lk_match    = '0;
        upd_match   = '0;
        lk_way      = '0;
        upd_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            lk_match[w]  = tbl[lk_idx][w].valid  && (tbl[lk_idx][w].tag  == lk_tag);
            upd_match[w] = tbl[upd_idx][w].valid && (tbl[upd_idx][w].tag == upd_tag);
            if (lk_match[w]) begin
                lk_way = WAY_W'(w);
            end
            if (upd_match[w]) begin
                upd_hit_way = WAY_W'(w);
            end
        end
    end

    // rst gates the outputs so they are clean even before the first edge.
    assign flush_busy    = (state == FLUSH) && !rst;
    assign lookup_hit    = lookup_valid && !rst && (state == IDLE) && (|lk_match);
    assign lookup_target = lookup_hit ? tbl[lk_idx][lk_way].target
                                      : lookup_pc + ADDR_WIDTH'(4);

    // Updates only land in IDLE; a flush request in the same cycle wins.
    assign upd_hit  = |upd_match;
    assign upd_en   = upd_valid && !rst && (state == IDLE) && !flush_req;
    assign wr_en    = upd_en && upd_taken;
    assign inv_en   = upd_en && !upd_taken && upd_hit;
    assign upd_way  = upd_hit ? upd_hit_way : set_victim[upd_idx];
    // Any update attempt this cycle suppresses the lookup touch.
    assign lk_touch = lookup_hit && !upd_valid;

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        logic [NUM_WAYS-1:0] valid_vec;
        logic                set_touch;
        logic                set_clear;
        logic [WAY_W-1:0]    set_touch_way;

        always_comb begin
            valid_vec = '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_vec[w] = tbl[s][w].valid;
            end
        end

        assign set_touch     = (wr_en && (upd_idx == IDX_W'(s)))
                            || (lk_touch && (lk_idx == IDX_W'(s)));
        assign set_touch_way = wr_en ? upd_way : lk_way;
        assign set_clear     = (state == FLUSH) && (flush_cnt == IDX_W'(s));

        btb_lru_set #(
            .NUM_WAYS (NUM_WAYS)
        ) u_lru (
            .clk        (clk),
            .rst        (rst),
            .clear      (set_clear),
            .touch_en   (set_touch),
            .touch_way  (set_touch_way),
            .valid      (valid_vec),
            .victim_way (set_victim[s])
        );
    end

    // Tags and targets are data and are never reset; only valid bits are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl[upd_idx][upd_way].tag    <= upd_tag;
            tbl[upd_idx][upd_way].target <= upd_target;
        end
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tbl[s][w].valid <= 1'b0;
                end
            end
        end else if (state == FLUSH) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                tbl[flush_cnt][w].valid <= 1'b0;
            end
        end else if (wr_en) begin
            tbl[upd_idx][upd_way].valid <= 1'b1;
        end else if (inv_en) begin
            tbl[upd_idx][upd_hit_way].valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                flush_cnt_nxt = flush_cnt + 1'b1;
                if (flush_cnt == IDX_W'(NUM_SETS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter NUM_SETS, default 4: number of sets; power of two, at least 2.
REQ-002 SHALL have parameter NUM_WAYS, default 4: ways per set; power of two, at least 2.
REQ-003 SHALL take ADDR_WIDTH (byte address width, 26) from the shared mips_core package; it is not a local parameter.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 lookup_pc  in  ADDR_WIDTH  fetch PC to look up.
REQ-007 lookup_valid  in  1  lookup_pc is a real request this cycle.
REQ-008 lookup_hit  out  1  a matching valid entry exists (combinational).
REQ-009 lookup_target  out  ADDR_WIDTH  target of the hit entry; lookup_pc + 4 on miss.
REQ-010 upd_valid  in  1  a branch/jump resolved in EX this cycle.
REQ-011 upd_pc  in  ADDR_WIDTH  PC of the resolved instruction.
REQ-012 upd_taken  in  1  resolved direction (1 = taken).
REQ-013 upd_target  in  ADDR_WIDTH  resolved target.
REQ-014 flush_req  in  1  one-cycle request to invalidate the whole table.
REQ-015 flush_busy  out  1  flush walk in progress.

Function
REQ-016 Index SHALL be pc[2 +: log2(NUM_SETS)]; tag SHALL be pc[ADDR_WIDTH-1 : 2+log2(NUM_SETS)]; pc[1:0] SHALL be ignored.
REQ-017 Lookup SHALL be combinational with zero latency; lookup_hit = lookup_valid & !flush_busy & any way in set with valid & tag match.
REQ-018 At most one way SHALL match per set; updates enforce this by refreshing an existing match instead of allocating a second entry.
REQ-019 Table writes SHALL become visible to lookup on the cycle after the update; a same-cycle lookup sees the old contents.
REQ-020 Taken update with a tag hit SHALL rewrite that way's target and mark the way most recently used (MRU).
REQ-021 Taken update with a tag miss SHALL allocate a way: the lowest-index invalid way; if none is invalid, the way with the maximum age. It SHALL write valid, tag and target, and mark the way MRU.
REQ-022 Not-taken update with a tag hit SHALL clear that way's valid bit and leave ages unchanged; a not-taken update with a miss SHALL do nothing.
REQ-023 Each way SHALL hold an age of log2(NUM_WAYS) bits; within a set the ages SHALL always be a permutation of 0..NUM_WAYS-1.
REQ-024 Touching way w with age a SHALL set age[w] = 0 and increment every way in the set whose age is less than a.
REQ-025 A lookup hit SHALL touch the hit way only when upd_valid is 0 that cycle; an update touch takes priority.
REQ-026 FSM states SHALL be IDLE and FLUSH; flush_req in IDLE SHALL move to FLUSH on the next edge with set counter = 0.
REQ-027 In FLUSH, each cycle SHALL clear all valid bits of set[counter], reset that set's ages to age[w] = w, and increment the counter.
REQ-028 After clearing set NUM_SETS-1 the FSM SHALL return to IDLE, so flush_busy is high for exactly NUM_SETS cycles.
REQ-029 flush_req during FLUSH SHALL be ignored; upd_valid during FLUSH SHALL be dropped.
REQ-030 flush_req and upd_valid together in IDLE: the update SHALL be dropped and the flush started.
REQ-031 Rst asserted mid-flush SHALL abort the walk and apply the reset state of REQ-032 to REQ-034.

Reset
REQ-032 On the first edge with rst high, all valid bits SHALL be cleared and every set's ages SHALL become age[w] = w.
REQ-033 On the same edge, the FSM SHALL go to IDLE and the set counter SHALL go to 0.
REQ-034 While rst is high, flush_busy and lookup_hit SHALL read 0 and lookup_target SHALL read lookup_pc + 4; tags and targets need not be reset.

Structure
REQ-035 The btb_entry struct (valid, tag, target) and the FSM state enum SHALL live in the shared mips_core package.
REQ-036 Per-set replacement and age-update logic SHALL be one sub-module, btb_lru_set, instantiated NUM_SETS times.

Verification
REQ-037 After reset, lookup 0x40 -> hit = 0, target = 0x44.
REQ-038 Taken update pc 0x40, target 0x100; lookup 0x40 on the same cycle -> miss; lookup 0x40 on the next cycle -> hit, target 0x100.
REQ-039 With defaults, fill set 0 with taken updates at 0x00, 0x10, 0x20, 0x30, look up 0x00 to touch it, then update 0x40 -> 0x10 evicted; 0x00, 0x20, 0x30, 0x40 hit.
REQ-040 Not-taken update of 0x40 after it is installed -> the next lookup of 0x40 misses; other ways unchanged.
REQ-041 Flush_req with updates held every cycle -> flush_busy high for 4 cycles, all lookups miss during and after, no update installed.
REQ-042 Rst pulsed on flush cycle 2, then lookup of any PC installed before the flush -> miss, flush_busy = 0; a new flush_req walks the full 4 cycles.
